instruction_memory_ctrl: RTL and testbench
==========================================

// Module: instruction_memory_ctrl
// PURPOSE
//   Parametrised, synchronous, loadable instruction memory. It sits between the
//   PC/fetch stage and the decoder: it takes byte-addressed fetch requests over a
//   valid/ready handshake and returns one DATA_W-bit instruction word per accepted
//   request, one cycle later. A word-wide load port lets the test harness or boot
//   logic write the program at run time. After reset, an INIT sweep clears the
//   whole array, so that unloaded locations read as NOP (all zeros).
// PARAMETERS
//   ADDR_W  8   byte-address width of req_addr
//   DATA_W  32  instruction width
//   DEPTH   64  number of instruction words; must satisfy DEPTH <= 2**(ADDR_W-2)
// PORTS
//   clk        in   1          rising-edge clock
//   rst_n      in   1          async active-low reset
//   init_done  out  1          1 once the clear sweep has finished
//   req_valid  in   1          fetch request valid
//   req_ready  out  1          fetch request accepted when valid&&ready
//   req_addr   in   ADDR_W     byte address; word index = req_addr[ADDR_W-1:2]
//   rsp_valid  out  1          response valid
//   rsp_ready  in   1          consumer accepts response
//   rsp_instr  out  DATA_W     fetched instruction
//   rsp_fault  out  1          1 = misaligned request (req_addr[1:0] != 0)
//   ld_en      in   1          write ld_data to mem[ld_addr] this cycle
//   ld_addr    in   ADDR_W-2   word index for load
//   ld_data    in   DATA_W     load data
// BEHAVIOUR
//   Reset (async, rst_n=0): state=INIT, sweep_cnt=0, init_done=0, rsp_valid=0,
//     rsp_instr=0, rsp_fault=0. Memory contents are not reset directly.
//   FSM INIT: each clk writes 0 to mem[sweep_cnt] and increments sweep_cnt.
//     The write with sweep_cnt==DEPTH-1 moves the FSM to RUN. init_done=1 from
//     the DEPTH-th rising edge after rst_n deasserts. ld_en and req_valid are
//     ignored in INIT (req_ready=0).
//   FSM RUN: stays in RUN until reset. There is no other exit.
//   req_ready = init_done && !ld_en && (!rsp_valid || rsp_ready).
//     Load has priority over fetch.
//   Accept (req_valid && req_ready) at edge N: at edge N, rsp_valid<=1 and
//     rsp_instr/rsp_fault are loaded, so they are visible in cycle N+1.
//     Latency is 1 cycle, and full throughput (1/cycle) is sustained while
//     rsp_ready=1.
//   Response content:
//     misaligned      -> rsp_instr=0, rsp_fault=1
//     word idx>=DEPTH -> rsp_instr=0 (NOP), rsp_fault=0
//     otherwise       -> rsp_instr=mem[idx], rsp_fault=0
//   Back-pressure: while rsp_valid && !rsp_ready, rsp_instr/rsp_fault/rsp_valid
//     hold stable and no new request is accepted.
//   rsp_valid drops to 0 on an edge with rsp_ready=1 and no accept.
//   Load (RUN, ld_en=1): mem[ld_addr] <= ld_data at the edge.
//     ld_addr >= DEPTH: the write is dropped silently.
//     A held response is not altered by a later load to the same word.
//   Reset mid-operation: outputs return to reset values immediately, any pending
//     response is discarded, and a full INIT sweep reruns, so prior loads are lost.
// TESTING
//   1. Reset release, DEPTH=64 -> init_done=0 for 63 edges and 1 at the 64th;
//      req_ready=0 throughout INIT.
//   2. ld word 1=32'h41000010, then fetch req_addr=8'd4 -> next cycle
//      rsp_valid=1, rsp_instr=32'h41000010, rsp_fault=0.
//      Unloaded addr 8'd8 -> 32'h00000000.
//   3. Fetch req_addr=8'd6 -> rsp_instr=0, rsp_fault=1. With DEPTH=16,
//      req_addr=8'd64 -> rsp_instr=0, rsp_fault=0.
//   4. Back-to-back fetches 0,4,8 with rsp_ready=1 -> 3 responses on 3
//      consecutive cycles. Then hold rsp_ready=0 for 3 cycles ->
//      req_ready=0 and the response stays constant.
//   5. Assert ld_en (word 2=32'h42000001) and req_valid (addr 8'd8) in the same
//      cycle -> req_ready=0. The fetch is accepted next cycle and returns
//      32'h42000001.
//   6. Drop rst_n while rsp_valid=1 -> rsp_valid=0 asynchronously. After the
//      re-sweep, the previously loaded word 1 reads 0.

Source files
------------

// File: rtl/instruction_memory_ctrl.sv
// Loadable instruction memory with a byte-addressed valid/ready fetch port and
// a one-cycle registered response; a post-reset sweep clears every word to NOP.
module instruction_memory_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              init_done,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic              rsp_fault,
  input  logic              ld_en,
  input  logic [ADDR_W-3:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**(ADDR_W-2) still compares correctly.
  localparam logic [ADDR_W-2:0] DEPTH_X = (ADDR_W-1)'(DEPTH);

  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_nxt;

  logic [IW-1:0]     sweep_cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-3:0] req_idx;
  logic              req_misal, req_in_range, ld_in_range, accept;

  assign req_idx      = req_addr[ADDR_W-1:2];
  assign req_misal    = |req_addr[1:0];
  assign req_in_range = {1'b0, req_idx} < DEPTH_X;
  assign ld_in_range  = {1'b0, ld_addr} < DEPTH_X;
  assign accept       = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == INIT && sweep_cnt == IW'(DEPTH-1)) state_nxt = RUN;
  end

  always_comb begin
    init_done = (state == RUN);
    req_ready = init_done && !ld_en && (!rsp_valid || rsp_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              sweep_cnt <= '0;
    else if (state == INIT)  sweep_cnt <= sweep_cnt + IW'(1);
  end

  // Array itself is never reset; the sweep owns the write port during INIT.
  always_ff @(posedge clk) begin
    if (state == INIT)              mem[sweep_cnt]       <= '0;
    else if (ld_en && ld_in_range)  mem[ld_addr[IW-1:0]] <= ld_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_instr <= '0;
      rsp_fault <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_fault <= req_misal;
      rsp_instr <= (!req_misal && req_in_range) ? mem[req_idx[IW-1:0]] : '0;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_instruction_memory_ctrl.sv
// Bench for instruction_memory_ctrl: abstract memory model checked every cycle,
// plus directed literal checks; a DEPTH=16 instance covers the range boundary.
module tb_instruction_memory_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, rsp_ready = 1'b1, ld_en = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [5:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic        init_done, req_ready, rsp_valid, rsp_fault;
  logic [31:0] rsp_instr;
  logic        b_init_done, b_req_ready, b_rsp_valid, b_rsp_fault;
  logic [31:0] b_rsp_instr;
  int n_err = 0, n_chk = 0;

  always #5 clk = ~clk;

  instruction_memory_ctrl #(.ADDR_W(8), .DATA_W(32), .DEPTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done), .req_valid(req_valid),
    .req_ready(req_ready), .req_addr(req_addr), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_instr(rsp_instr), .rsp_fault(rsp_fault),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

  instruction_memory_ctrl #(.ADDR_W(8), .DATA_W(32), .DEPTH(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .init_done(b_init_done), .req_valid(req_valid),
    .req_ready(b_req_ready), .req_addr(req_addr), .rsp_valid(b_rsp_valid),
    .rsp_ready(rsp_ready), .rsp_instr(b_rsp_instr), .rsp_fault(b_rsp_fault),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the array is simply all-zero after reset; init lasts DEPTH edges.
  logic [31:0] m_mem [64];
  int          m_edges;
  logic        m_rv, m_rf, m_init, m_ready;
  logic [31:0] m_ri;
  logic [5:0]  m_idx;
  assign m_init  = (m_edges >= 64);
  assign m_ready = m_init && !ld_en && (!m_rv || rsp_ready);
  assign m_idx   = req_addr[7:2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edges <= 0; m_rv <= 1'b0; m_ri <= '0; m_rf <= 1'b0;
      for (int i = 0; i < 64; i++) m_mem[i] <= '0;
    end else begin
      if (!m_init) m_edges <= m_edges + 1;
      else if (ld_en) m_mem[ld_addr] <= ld_data;
      if (m_ready && req_valid) begin
        m_rv <= 1'b1;
        m_rf <= (req_addr[1:0] != 2'b00);
        m_ri <= (req_addr[1:0] != 2'b00) ? 32'h0 : m_mem[m_idx];
      end else if (rsp_ready) begin
        m_rv <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_init_done", init_done, m_init);
      chk("cyc_req_ready", req_ready, m_ready);
      chk("cyc_rsp_valid", rsp_valid, m_rv);
      if (m_rv) begin
        chk("cyc_rsp_instr", rsp_instr, m_ri);
        chk("cyc_rsp_fault", rsp_fault, m_rf);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_init();
    int n = 0, nb = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      n++;
      if (b_init_done && nb == 0) nb = n;
      if (init_done) break;
    end
    chk("init_edges_d64", n, 64);
    chk("init_edges_d16", nb, 16);
  endtask

  task automatic load(input logic [5:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic fetch(input logic [7:0] a);
    req_valid = 1'b1; req_addr = a;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    chk("reset_init_done", init_done, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    wait_init();

    load(6'd1, 32'h41000010);
    fetch(8'd4);
    chk("ld_fetch_valid", rsp_valid, 1);
    chk("ld_fetch_instr", rsp_instr, 32'h41000010);
    chk("ld_fetch_fault", rsp_fault, 0);
    fetch(8'd8);
    chk("unloaded_nop", rsp_instr, 32'h0);

    fetch(8'd6);
    chk("misal_instr", rsp_instr, 32'h0);
    chk("misal_fault", rsp_fault, 1);
    load(6'd15, 32'h0F0F0F0F);
    load(6'd16, 32'h16161616);
    fetch(8'd60);
    chk("b_last_word", b_rsp_instr, 32'h0F0F0F0F);
    fetch(8'd64);
    chk("b_oob_instr", b_rsp_instr, 32'h0);
    chk("b_oob_fault", b_rsp_fault, 0);
    chk("b_oob_valid", b_rsp_valid, 1);
    chk("a_word16", rsp_instr, 32'h16161616);

    load(6'd0, 32'h00000013);
    load(6'd2, 32'h00A00093);
    req_valid = 1'b1;
    req_addr = 8'd0; tick(); chk("b2b_0", rsp_instr, 32'h00000013);
    req_addr = 8'd4; tick(); chk("b2b_4", rsp_instr, 32'h41000010);
    req_addr = 8'd8; tick(); chk("b2b_8", rsp_instr, 32'h00A00093);
    chk("b2b_valid", rsp_valid, 1);
    req_valid = 1'b0;
    tick();
    chk("drop_valid", rsp_valid, 0);

    fetch(8'd4);
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 8'd8;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin ld_en = 1'b1; ld_addr = 6'd1; ld_data = 32'hDEADBEEF; end
      else ld_en = 1'b0;
      #1 chk("bp_req_ready", req_ready, 0);
      tick();
      chk("bp_hold_instr", rsp_instr, 32'h41000010);
      chk("bp_hold_valid", rsp_valid, 1);
    end
    ld_en = 1'b0; rsp_ready = 1'b1;
    #1 chk("bp_release_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("bp_next_instr", rsp_instr, 32'h00A00093);

    ld_en = 1'b1; ld_addr = 6'd2; ld_data = 32'h42000001;
    req_valid = 1'b1; req_addr = 8'd8;
    #1 chk("ld_prio_ready", req_ready, 0);
    tick();
    ld_en = 1'b0;
    #1 chk("ld_prio_ready_after", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("ld_prio_instr", rsp_instr, 32'h42000001);

    fetch(8'd4);
    chk("pre_rst_instr", rsp_instr, 32'hDEADBEEF);
    #2 rst_n = 1'b0;
    #1 chk("async_rsp_valid", rsp_valid, 0);
    chk("async_init_done", init_done, 0);
    chk("async_rsp_instr", rsp_instr, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    wait_init();
    fetch(8'd4);
    chk("post_rst_word1", rsp_instr, 32'h0);
    fetch(8'd8);
    chk("post_rst_word2", rsp_instr, 32'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
